fifo_stream_reader: RTL and testbench

- Read-side drain engine for the 16x16 synchronous FIFO.
- Drives the FIFO read strobe from fifo_empty and absorbs the FIFO's one-cycle registered read latency.
- Presents the words on a valid/ready stream to the downstream consumer with full throughput and no word loss.
- Sits between FIFO_16_16 (read port) and any consumer block.

---
 rtl/fifo_stream_reader.sv | 87 ++++++++
 tb/tb_fifo_stream_reader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_reader
// Description : Drains a registered-read FIFO into a valid/ready stream through
//               a 2-entry skid buffer, sustaining one word per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             flush,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_out,
    output logic             read,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] word_count,
    output logic             busy
);

    logic [1:0]       occ_q, occ_d;
    logic             pending_q, pending_d;
    logic [WIDTH-1:0] entry0_q, entry0_d;
    logic [WIDTH-1:0] entry1_q, entry1_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop;
    logic [1:0]       occ_after_pop;
    logic [2:0]       committed;

    always_comb begin
        pop           = (occ_q != 2'd0) && out_ready;
        // Slots already spoken for once this cycle's pop has left the buffer.
        committed     = {1'b0, occ_q} + {2'b00, pending_q} - {2'b00, pop};
        read          = reset && enable && !flush && !fifo_empty && (committed < 3'd2);
        occ_after_pop = occ_q - {1'b0, pop};

        entry0_d  = entry0_q;
        entry1_d  = entry1_q;
        occ_d     = occ_after_pop;
        pending_d = read;
        count_d   = count_q + {{(CNT_W-1){1'b0}}, pop};

        if (pop) begin
            entry0_d = entry1_q;
        end

        if (flush) begin
            occ_d     = 2'd0;
            pending_d = 1'b0;
        end else if (pending_q) begin
            // The returning word lands at the tail after the pop shift.
            case (occ_after_pop)
                2'd0:    entry0_d = fifo_out;
                default: entry1_d = fifo_out;
            endcase
            occ_d = occ_after_pop + 2'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            occ_q     <= 2'd0;
            pending_q <= 1'b0;
            entry0_q  <= '0;
            entry1_q  <= '0;
            count_q   <= '0;
        end else begin
            occ_q     <= occ_d;
            pending_q <= pending_d;
            entry0_q  <= entry0_d;
            entry1_q  <= entry1_d;
            count_q   <= count_d;
        end
    end

    assign out_valid  = (occ_q != 2'd0);
    assign out_data   = entry0_q;
    assign word_count = count_q;
    assign busy       = (occ_q != 2'd0) || pending_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_stream_reader
// Description : Directed self-checking bench with a registered-read FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

    localparam int WIDTH = 16;
    localparam int CNT_W = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic             flush = 1'b0;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_out = '0;
    logic             read;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] word_count;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] fifo_mem [0:255];
    int               wr_ptr = 0;
    int               rd_ptr = 0;
    logic [WIDTH-1:0] rx_mem [0:255];
    int               rx_n = 0;
    logic             underflow = 1'b0;

    fifo_stream_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_out   (fifo_out),
        .read       (read),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .word_count (word_count),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // FIFO model: read data appears the cycle after the strobe.
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clock) begin
        if (read) begin
            if (fifo_empty) underflow <= 1'b1;
            fifo_out <= fifo_mem[rd_ptr[7:0]];
            rd_ptr   <= rd_ptr + 1;
        end
    end

    always @(posedge clock) begin
        if (reset && out_valid && out_ready) begin
            rx_mem[rx_n[7:0]] <= out_data;
            rx_n              <= rx_n + 1;
        end
    end

    task automatic load(input logic [WIDTH-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr[7:0]] = first + WIDTH'(i);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic test_reset;
        @(negedge clock);
        load(16'h0001, 5);
        enable    = 1'b1;
        out_ready = 1'b1;
        #1;
        n_checks++; if (read !== 1'b0) begin n_fail++; $display("FAIL reset_read got=%0b exp=0", read); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        n_checks++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data got=%h exp=0000", out_data); end
        n_checks++; if (word_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", word_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_stream;
        logic [9:0] rlog;
        logic [9:0] vlog;
        int base;
        base = rx_n;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            rlog[i] = read;
            vlog[i] = out_valid;
            @(negedge clock);
        end
        #1;
        n_checks++; if (rlog !== 10'b0000011111) begin n_fail++; $display("FAIL stream_read_pattern got=%b exp=0000011111", rlog); end
        n_checks++; if (vlog !== 10'b0001111100) begin n_fail++; $display("FAIL stream_valid_pattern got=%b exp=0001111100", vlog); end
        n_checks++; if (rx_n - base !== 5) begin n_fail++; $display("FAIL stream_words got=%0d exp=5", rx_n - base); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rx_mem[(base + i) % 256] !== 16'h0001 + WIDTH'(i)) begin
                n_fail++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, rx_mem[(base + i) % 256], 16'h0001 + WIDTH'(i));
            end
        end
        n_checks++; if (word_count !== 16'd5) begin n_fail++; $display("FAIL stream_count got=%0d exp=5", word_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stream_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_backpressure;
        int base;
        int rc;
        logic gap;
        base = rx_n;
        rc   = 0;
        gap  = 1'b0;
        load(16'hA000, 10);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            rc += int'(read);
            @(negedge clock);
        end
        #1;
        n_checks++; if (rc !== 2) begin n_fail++; $display("FAIL bp_read_count got=%0d exp=2", rc); end
        n_checks++; if (read !== 1'b0) begin n_fail++; $display("FAIL bp_read_held got=%0b exp=0", read); end
        n_checks++; if (out_data !== 16'hA000) begin n_fail++; $display("FAIL bp_head got=%h exp=a000", out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 40 && (rx_n - base) < 10; i++) begin
            #1;
            if (!out_valid && (rx_n - base) > 0) gap = 1'b1;
            @(negedge clock);
        end
        #1;
        n_checks++; if (rx_n - base !== 10) begin n_fail++; $display("FAIL bp_words got=%0d exp=10", rx_n - base); end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (rx_mem[(base + i) % 256] !== 16'hA000 + WIDTH'(i)) begin
                n_fail++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, rx_mem[(base + i) % 256], 16'hA000 + WIDTH'(i));
            end
        end
        n_checks++; if (gap !== 1'b0) begin n_fail++; $display("FAIL bp_gap got=%0b exp=0", gap); end
        n_checks++; if (word_count !== 16'd15) begin n_fail++; $display("FAIL bp_count got=%0d exp=15", word_count); end
    endtask

    task automatic test_toggle_ready;
        int base;
        base = rx_n;
        load(16'hB000, 8);
        for (int i = 0; i < 40; i++) begin
            out_ready = (i % 2 == 0);
            #1;
            @(negedge clock);
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (rx_n - base !== 8) begin n_fail++; $display("FAIL toggle_words got=%0d exp=8", rx_n - base); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (rx_mem[(base + i) % 256] !== 16'hB000 + WIDTH'(i)) begin
                n_fail++; $display("FAIL toggle_data[%0d] got=%h exp=%h", i, rx_mem[(base + i) % 256], 16'hB000 + WIDTH'(i));
            end
        end
        n_checks++; if (word_count !== 16'd23) begin n_fail++; $display("FAIL toggle_count got=%0d exp=23", word_count); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL toggle_underflow got=%0b exp=0", underflow); end
    endtask

    task automatic test_flush;
        int base;
        logic [WIDTH-1:0] exp_w [0:4];
        exp_w[0] = 16'hC000; exp_w[1] = 16'hC002; exp_w[2] = 16'hC003;
        exp_w[3] = 16'hC004; exp_w[4] = 16'hC005;
        @(negedge clock);
        base = rx_n;
        load(16'hC000, 6);
        out_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        n_checks++; if (read !== 1'b0) begin n_fail++; $display("FAIL flush_read got=%0b exp=0", read); end
        n_checks++; if (out_data !== 16'hC000) begin n_fail++; $display("FAIL flush_head got=%h exp=c000", out_data); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before got=%0b exp=1", busy); end
        @(negedge clock);
        flush = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid_after got=%0b exp=0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_after got=%0b exp=0", busy); end
        n_checks++; if (word_count !== 16'd24) begin n_fail++; $display("FAIL flush_count got=%0d exp=24", word_count); end
        for (int i = 0; i < 20; i++) @(negedge clock);
        #1;
        n_checks++; if (rx_n - base !== 5) begin n_fail++; $display("FAIL flush_words got=%0d exp=5", rx_n - base); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rx_mem[(base + i) % 256] !== exp_w[i]) begin
                n_fail++; $display("FAIL flush_data[%0d] got=%h exp=%h", i, rx_mem[(base + i) % 256], exp_w[i]);
            end
        end
        n_checks++; if (word_count !== 16'd28) begin n_fail++; $display("FAIL flush_count_end got=%0d exp=28", word_count); end
    endtask

    task automatic test_enable;
        int base;
        int rc;
        @(negedge clock);
        base = rx_n;
        rc   = 0;
        load(16'hD000, 4);
        #1;
        n_checks++; if (read !== 1'b1) begin n_fail++; $display("FAIL en_first_read got=%0b exp=1", read); end
        @(negedge clock);
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            rc += int'(read);
            @(negedge clock);
        end
        #1;
        n_checks++; if (rc !== 0) begin n_fail++; $display("FAIL en_reads_while_off got=%0d exp=0", rc); end
        n_checks++; if (rx_n - base !== 1) begin n_fail++; $display("FAIL en_pending_delivered got=%0d exp=1", rx_n - base); end
        n_checks++; if (word_count !== 16'd29) begin n_fail++; $display("FAIL en_count_off got=%0d exp=29", word_count); end
        enable = 1'b1;
        for (int i = 0; i < 20; i++) @(negedge clock);
        #1;
        n_checks++; if (rx_n - base !== 4) begin n_fail++; $display("FAIL en_words got=%0d exp=4", rx_n - base); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rx_mem[(base + i) % 256] !== 16'hD000 + WIDTH'(i)) begin
                n_fail++; $display("FAIL en_data[%0d] got=%h exp=%h", i, rx_mem[(base + i) % 256], 16'hD000 + WIDTH'(i));
            end
        end
        n_checks++; if (word_count !== 16'd32) begin n_fail++; $display("FAIL en_count got=%0d exp=32", word_count); end
    endtask

    task automatic test_async_reset;
        int base;
        logic [WIDTH-1:0] exp_w [0:7];
        exp_w[0] = 16'hE000; exp_w[1] = 16'hE001;
        for (int i = 0; i < 6; i++) exp_w[i + 2] = 16'hE004 + WIDTH'(i);
        @(negedge clock);
        base = rx_n;
        load(16'hE000, 10);
        repeat (4) @(negedge clock);
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL arst_busy_before got=%0b exp=1", busy); end
        #1;
        reset = 1'b0;
        #1;
        n_checks++; if (read !== 1'b0) begin n_fail++; $display("FAIL arst_read got=%0b exp=0", read); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got=%0b exp=0", out_valid); end
        n_checks++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL arst_data got=%h exp=0000", out_data); end
        n_checks++; if (word_count !== 16'd0) begin n_fail++; $display("FAIL arst_count got=%0d exp=0", word_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got=%0b exp=0", busy); end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 30; i++) @(negedge clock);
        #1;
        n_checks++; if (rx_n - base !== 8) begin n_fail++; $display("FAIL arst_words got=%0d exp=8", rx_n - base); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (rx_mem[(base + i) % 256] !== exp_w[i]) begin
                n_fail++; $display("FAIL arst_data[%0d] got=%h exp=%h", i, rx_mem[(base + i) % 256], exp_w[i]);
            end
        end
        n_checks++; if (word_count !== 16'd6) begin n_fail++; $display("FAIL arst_count_end got=%0d exp=6", word_count); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL arst_underflow got=%0b exp=0", underflow); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle_ready();
        test_flush();
        test_enable();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
